// File: rtl/i2c_slave_read.sv
// I2C slave receive engine: samples SDA on each SCL rise, reports START/STOP and bus errors.
// Strobes are combinational on the current bus sample; bus state and data_byte are registered.
module i2c_slave_read (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_en,
  input  logic       is_byte,
  output logic       rd_vld,
  output logic       data_o,
  output logic [7:0] data_byte,
  output logic       rd_finish,
  output logic       get_start,
  output logic       get_stop,
  output logic       bus_err,
  input  logic       scl_i,
  input  logic       sda_i
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, WAIT_FALL, DONE} state_t;

  state_t     state_q;
  logic       scl_q;
  logic       sda_q;
  logic [2:0] cnt_q;
  logic       last_q;
  logic       byte_q;
  logic [7:0] data_byte_q;

  logic scl_rise, scl_fall, sda_rise, sda_fall, scl_hold_hi;
  logic in_rise, in_fall;

  assign scl_rise    = scl_i & ~scl_q;
  assign scl_fall    = ~scl_i & scl_q;
  assign sda_rise    = sda_i & ~sda_q;
  assign sda_fall    = ~sda_i & sda_q;
  // SDA edges only count while SCL stays high across both samples, so a
  // simultaneous SCL/SDA change is seen purely as an SCL edge.
  assign scl_hold_hi = scl_i & scl_q;

  assign in_rise = (state_q == WAIT_RISE) & rd_en;
  assign in_fall = (state_q == WAIT_FALL) & rd_en;

  assign get_start = scl_hold_hi & sda_fall;
  assign get_stop  = scl_hold_hi & sda_rise;
  assign rd_vld    = in_rise & scl_rise;
  assign data_o    = rd_vld & sda_i;
  assign bus_err   = in_fall & scl_hold_hi & (sda_rise | sda_fall);
  assign rd_finish = bus_err | (in_fall & scl_fall & ~(byte_q & ~last_q));
  assign data_byte = data_byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      cnt_q       <= 3'd0;
      last_q      <= 1'b0;
      byte_q      <= 1'b0;
      data_byte_q <= 8'h00;
    end else begin
      scl_q <= scl_i;
      sda_q <= sda_i;
      case (state_q)
        IDLE: begin
          if (rd_en && !scl_i) begin
            state_q     <= WAIT_RISE;
            byte_q      <= is_byte;
            cnt_q       <= 3'd0;
            last_q      <= 1'b0;
            data_byte_q <= 8'h00;
          end
        end
        WAIT_RISE: begin
          if (!rd_en) begin
            state_q <= IDLE;
          end else if (scl_rise) begin
            data_byte_q <= {data_byte_q[6:0], sda_i};
            cnt_q       <= cnt_q + 3'd1;
            // The counter wraps on the 8th bit, so remember that it was the last one.
            last_q      <= (cnt_q == 3'd7);
            state_q     <= WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (!rd_en) begin
            state_q <= IDLE;
          end else if (rd_finish) begin
            state_q <= DONE;
          end else if (scl_fall) begin
            state_q <= WAIT_RISE;
          end
        end
        DONE: begin
          if (!rd_en) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_read.sv
// Directed and randomized bench for i2c_slave_read; expectations come from the bytes sent.
module tb_i2c_slave_read;

  logic       clk = 1'b0;
  logic       rst_n, rd_en, is_byte, scl_i, sda_i;
  logic       rd_vld, data_o, rd_finish, get_start, get_stop, bus_err;
  logic [7:0] data_byte;

  i2c_slave_read dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .is_byte(is_byte),
    .rd_vld(rd_vld), .data_o(data_o), .data_byte(data_byte), .rd_finish(rd_finish),
    .get_start(get_start), .get_stop(get_stop), .bus_err(bus_err),
    .scl_i(scl_i), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitor state, sampled on the falling clock edge
  int         n_vld, n_fin, n_err, n_start, n_stop, n_errfin, n_vld_after_fin;
  logic       fin_scl;
  logic [7:0] fin_byte;
  logic       bits_q[$];
  logic       exp_bits[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rd_vld) begin
        n_vld++;
        bits_q.push_back(data_o);
        if (n_fin != 0) n_vld_after_fin++;
      end
      if (rd_finish) begin
        n_fin++;
        fin_byte = data_byte;
        fin_scl  = scl_i;
      end
      if (bus_err) n_err++;
      if (bus_err && rd_finish) n_errfin++;
      if (get_start) n_start++;
      if (get_stop) n_stop++;
    end
  end

  task automatic clear_mon();
    n_vld = 0; n_fin = 0; n_err = 0; n_start = 0; n_stop = 0;
    n_errfin = 0; n_vld_after_fin = 0;
    fin_scl = 1'bx; fin_byte = 8'hxx;
    bits_q.delete();
    exp_bits.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period of 8 clk: data set while low, 4 low then 4 high.
  task automatic send_bit(input logic b);
    sda_i = b;
    tick(4);
    scl_i = 1'b1;
    tick(4);
    scl_i = 1'b0;
  endtask

  task automatic start_xfer(input logic isb);
    scl_i = 1'b0;
    tick(1);
    rd_en   = 1'b1;
    is_byte = isb;
    tick(1);
  endtask

  task automatic end_xfer();
    tick(2);
    rd_en = 1'b0;
    sda_i = 1'b1;
    tick(2);
    scl_i = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      exp_bits.push_back(v[i]);
    end
  endtask

  task automatic chk_bits(input string tag);
    chk({tag, "_nvld"}, n_vld, exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < bits_q.size(); i++)
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, bits_q[i]}, {31'd0, exp_bits[i]});
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_rd_vld"}, {31'd0, rd_vld}, 0);
    chk({tag, "_data_o"}, {31'd0, data_o}, 0);
    chk({tag, "_data_byte"}, {24'd0, data_byte}, 0);
    chk({tag, "_rd_finish"}, {31'd0, rd_finish}, 0);
    chk({tag, "_get_start"}, {31'd0, get_start}, 0);
    chk({tag, "_get_stop"}, {31'd0, get_stop}, 0);
    chk({tag, "_bus_err"}, {31'd0, bus_err}, 0);
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0; rd_en = 1'b0; is_byte = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    clear_mon();
    tick(3);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    tick(4);
    chk("post_reset_strobes", n_vld + n_fin + n_err + n_start + n_stop, 0);

    // Single ACK bit, SDA high then SDA low
    for (int b = 1; b >= 0; b--) begin
      clear_mon();
      start_xfer(1'b0);
      send_bit(b[0]);
      exp_bits.push_back(b[0]);
      end_xfer();
      chk_bits($sformatf("bitmode%0d", b));
      chk($sformatf("bitmode%0d_nfin", b), n_fin, 1);
      chk($sformatf("bitmode%0d_fin_on_scl_low", b), {31'd0, fin_scl}, 0);
      chk($sformatf("bitmode%0d_nerr", b), n_err, 0);
    end

    // Byte 0xA5, then extra SCL pulses while held in DONE
    clear_mon();
    start_xfer(1'b1);
    send_byte(8'hA5);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("a5_hold_byte", {24'd0, data_byte}, 32'hA5);
    end_xfer();
    chk_bits("a5");
    chk("a5_fin_byte", {24'd0, fin_byte}, 32'hA5);
    chk("a5_nfin", n_fin, 1);
    chk("a5_nerr", n_err, 0);
    chk("a5_vld_after_fin", n_vld_after_fin, 0);

    // Random bytes
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom_range(0, 255));
      clear_mon();
      start_xfer(1'b1);
      send_byte(v);
      end_xfer();
      chk_bits($sformatf("rnd%0d", k));
      chk($sformatf("rnd%0d_fin_byte", k), {24'd0, fin_byte}, {24'd0, v});
      chk($sformatf("rnd%0d_nfin", k), n_fin, 1);
    end

    // Byte 0x3C with SDA toggled while SCL high on the 4th bit
    clear_mon();
    v = 8'h3C;
    start_xfer(1'b1);
    for (int i = 7; i >= 5; i--) begin
      send_bit(v[i]);
      exp_bits.push_back(v[i]);
    end
    sda_i = v[4];
    exp_bits.push_back(v[4]);
    tick(4);
    scl_i = 1'b1;
    tick(1);
    sda_i = ~v[4];
    tick(3);
    scl_i = 1'b0;
    for (int i = 3; i >= 0; i--) send_bit(v[i]);
    end_xfer();
    chk_bits("berr");
    chk("berr_nerr", n_err, 1);
    chk("berr_nfin", n_fin, 1);
    chk("berr_same_cycle", n_errfin, 1);
    chk("berr_vld_after_fin", n_vld_after_fin, 0);

    // START then STOP with the engine disabled
    clear_mon();
    tick(2);
    sda_i = 1'b0;
    tick(3);
    sda_i = 1'b1;
    tick(3);
    chk("ss_nstart", n_start, 1);
    chk("ss_nstop", n_stop, 1);
    chk("ss_nerr", n_err, 0);
    chk("ss_nfin", n_fin, 0);

    // SCL and SDA moving together is only an SCL edge
    clear_mon();
    scl_i = 1'b0; sda_i = 1'b0;
    tick(3);
    scl_i = 1'b1; sda_i = 1'b1;
    tick(3);
    chk("simul_nstart", n_start, 0);
    chk("simul_nstop", n_stop, 0);

    // Abort after 5 bits, then a fresh 0xFF
    clear_mon();
    v = 8'hB6;
    start_xfer(1'b1);
    for (int i = 7; i >= 3; i--) begin
      send_bit(v[i]);
      exp_bits.push_back(v[i]);
    end
    tick(1);
    rd_en = 1'b0;
    tick(2);
    send_bit(1'b1);
    send_bit(1'b0);
    chk_bits("abort");
    chk("abort_nfin", n_fin, 0);
    clear_mon();
    start_xfer(1'b1);
    send_byte(8'hFF);
    end_xfer();
    chk_bits("ff");
    chk("ff_fin_byte", {24'd0, fin_byte}, 32'hFF);
    chk("ff_data_byte", {24'd0, data_byte}, 32'hFF);
    chk("ff_nfin", n_fin, 1);

    // Reset in the middle of bit 2
    clear_mon();
    start_xfer(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    sda_i = 1'b1;
    tick(4);
    scl_i = 1'b1;
    tick(2);
    rst_n = 1'b0; rd_en = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    tick(1);
    chk_outs_zero("midreset");
    clear_mon();
    tick(1);
    rst_n = 1'b1;
    tick(6);
    chk("midreset_strobes", n_vld + n_fin + n_err + n_start + n_stop, 0);
    chk("midreset_data_byte", {24'd0, data_byte}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_read.md
I2C_SLAVE_READ -- requirements
Module: i2c_slave_read

Interface
REQ-001 SHALL provide port clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide port rd_en, input, 1, level enable from slave controller; transfer runs while high.
REQ-004 SHALL provide port is_byte, input, 1, 1 = receive 8 bits, 0 = receive 1 bit (ACK/NACK); latched at transfer start.
REQ-005 SHALL provide port rd_vld, output, 1, one-cycle strobe per received bit.
REQ-006 SHALL provide port data_o, output, 1, received bit, valid while rd_vld=1.
REQ-007 SHALL provide port data_byte, output, 8, MSB-first shift of received bits; final value valid from rd_finish.
REQ-008 SHALL provide port rd_finish, output, 1, one-cycle strobe at transfer end (normal or bus error).
REQ-009 SHALL provide port get_start, output, 1, one-cycle strobe on START (SDA fall while SCL high).
REQ-010 SHALL provide port get_stop, output, 1, one-cycle strobe on STOP (SDA rise while SCL high).
REQ-011 SHALL provide port bus_err, output, 1, one-cycle strobe on SDA change while SCL high inside a bit.
REQ-012 SHALL provide port scl_i, input, 1, I2C clock line, already synchronous to clk.
REQ-013 SHALL provide port sda_i, input, 1, I2C data line, already synchronous to clk.

Function
REQ-014 SHALL register scl_i/sda_i each cycle into scl_d/sda_d; rise = cur&~d, fall = ~cur&d, evaluated on current inputs.
REQ-015 SHALL implement states IDLE, WAIT_RISE, WAIT_FALL, DONE.
REQ-016 IDLE: rd_en=1 and scl_i=0 -> WAIT_RISE; latch is_byte; clear bit counter (3-bit) and data_byte.
REQ-017 IDLE with rd_en=1 and scl_i=1 SHALL remain in IDLE until SCL low.
REQ-018 WAIT_RISE: on SCL rise, same cycle, rd_vld=1, data_o=sda_i, data_byte<={data_byte[6:0],sda_i}, counter+1; next WAIT_FALL.
REQ-019 WAIT_FALL: SDA rise or fall with SCL high -> bus_err=1 and rd_finish=1 in that cycle; next DONE.
REQ-020 WAIT_FALL: on SCL fall, if latched is_byte=1 and fewer than 8 bits received -> WAIT_RISE; else rd_finish=1, next DONE.
REQ-021 Counter SHALL wrap 7->0 on the 8th bit; the 8-bit end condition uses a terminal flag, not counter value 0.
REQ-022 DONE: hold data_byte; rd_vld=0; exit to IDLE only when rd_en=0.
REQ-023 rd_en=0 in WAIT_RISE or WAIT_FALL SHALL abort to IDLE next cycle with no rd_finish and no further rd_vld.
REQ-024 get_start/get_stop SHALL be detected in every state, independent of rd_en.
REQ-025 In WAIT_FALL, START/STOP SHALL also raise bus_err in the same cycle.
REQ-026 SCL and SDA changing in the same cycle SHALL be treated as SCL edge only; no START/STOP/bus_err.
REQ-027 Module SHALL never drive SDA; no sda_o port.

Reset
REQ-028 On rst_n=0 SHALL force state IDLE, counter 0, data_byte 8'h00, all strobes 0, data_o 0.
REQ-029 On rst_n=0 SHALL set scl_d=1, sda_d=1 (idle bus), so no edges or START/STOP strobe follow reset release.
REQ-030 Reset mid-transfer SHALL discard partial data; no rd_finish after release.

Verification
REQ-031 Bit mode: rd_en 1 clk after SCL fall, SDA=1 over one SCL pulse -> one rd_vld with data_o=1; rd_finish on next SCL fall.
REQ-032 Byte mode: master sends 8'hA5 (8 SCL periods of 8 clk) -> 8 rd_vld, data_o 1,0,1,0,0,1,0,1; data_byte=8'hA5; one rd_finish.
REQ-033 Byte 8'h3C, SDA toggled 1 clk after SCL rise at bit 3 -> bus_err + rd_finish same cycle; exactly 4 rd_vld; no rd_vld after.
REQ-034 rd_en=0: SDA fall, then SDA rise, both with SCL high -> one get_start, one get_stop; no bus_err or rd_finish.
REQ-035 rd_en drops after bit 5 of a byte -> state IDLE; no rd_finish; re-enable and send 8'hFF -> data_byte=8'hFF.
REQ-036 rst_n pulsed low during bit 2 -> all outputs 0 after reset; no strobes on release with SCL=SDA=1.
